// File: rtl/tdc_thermo_encoder_if.sv
// Request channel of the TDC thermometer encoder: bin number plus valid/ready handshake.
// The source drives the master modport, the encoder takes the slave modport.
interface tdc_thermo_encoder_if #(
    parameter int BITS_DECO = 8
);
    logic                 i_bin_valid;
    logic [BITS_DECO-1:0] i_bin;
    logic                 o_bin_ready;

    modport master (output i_bin_valid, output i_bin, input o_bin_ready);
    modport slave  (input i_bin_valid, input i_bin, output o_bin_ready);
endinterface

// File: rtl/tdc_thermo_encoder.sv
// Bin-to-thermometer encoder emulating the TDC start FF column, with request FIFO and auto sweep.
// Optional feature: define TDC_BUBBLE_INJECT_EN to inject LFSR-driven, count-preserving bubbles.
module tdc_thermo_encoder #(
    parameter int NUM_FF     = 240,
    parameter int BITS_DECO  = 8,
    parameter int HOLD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdc_thermo_encoder_if.slave  req,
    input  logic                 i_sweep_start,
    input  logic [BITS_DECO-1:0] i_sweep_step,
    input  logic [HOLD_W-1:0]    i_hold_cycles,
    output logic [NUM_FF-1:0]    o_thermo,
    output logic                 o_thermo_valid,
    output logic [BITS_DECO-1:0] o_bin_echo,
    output logic                 o_sat,
    output logic                 o_bubble,
    output logic                 o_busy,
    output logic                 o_sweep_done
);
    localparam int BW    = BITS_DECO + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [BW-1:0] NUM_FF_B = BW'(NUM_FF);

    typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;

    // ---------------- request FIFO ----------------
    logic [BITS_DECO-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 fifo_full, fifo_empty, push_en, pop_en;

    assign fifo_full       = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty      = (count_reg == '0);
    assign req.o_bin_ready = !fifo_full;
    assign push_en         = req.i_bin_valid && !fifo_full;

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_reg] <= req.i_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- control ----------------
    state_t               state_reg, state_next;
    logic [HOLD_W-1:0]    cnt_reg, cnt_next;
    logic [BW-1:0]        sweep_bin_reg, sweep_bin_next;
    logic [BITS_DECO-1:0] step_reg, step_next;
    logic [BW-1:0]        fifo_bin, sweep_sum, load_bin;
    logic                 load_en, load_sat, clear_out, done_next;

    assign fifo_bin  = BW'(fifo_mem[rd_ptr_reg]);
    // BW bits hold NUM_FF plus a full step, so this sum never wraps
    assign sweep_sum = sweep_bin_reg + BW'(step_reg);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sweep_bin_next = sweep_bin_reg;
        step_next      = step_reg;
        pop_en         = 1'b0;
        load_en        = 1'b0;
        load_bin       = '0;
        load_sat       = 1'b0;
        clear_out      = 1'b0;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_sweep_start) begin
                    state_next     = SWEEP;
                    load_en        = 1'b1;
                    sweep_bin_next = '0;
                    step_next      = (i_sweep_step == '0) ? BITS_DECO'(1) : i_sweep_step;
                end else if (!fifo_empty) begin
                    state_next = HOLD;
                    pop_en     = 1'b1;
                    load_en    = 1'b1;
                    load_sat   = (fifo_bin > NUM_FF_B);
                    load_bin   = load_sat ? NUM_FF_B : fifo_bin;
                end
            end
            HOLD: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - HOLD_W'(1);
                end else if (!fifo_empty) begin
                    pop_en   = 1'b1;
                    load_en  = 1'b1;
                    load_sat = (fifo_bin > NUM_FF_B);
                    load_bin = load_sat ? NUM_FF_B : fifo_bin;
                end else begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                end
            end
            SWEEP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - HOLD_W'(1);
                end else if (sweep_bin_reg >= NUM_FF_B) begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    // an overshooting step lands exactly on NUM_FF so the full-ones word is never skipped
                    load_en        = 1'b1;
                    load_bin       = (sweep_sum > NUM_FF_B) ? NUM_FF_B : sweep_sum;
                    sweep_bin_next = load_bin;
                end
            end
            default: begin
                state_next = IDLE;
                clear_out  = 1'b1;
            end
        endcase
        if (load_en) begin
            cnt_next = i_hold_cycles;
        end
    end

    // ---------------- word encoding ----------------
    logic [NUM_FF-1:0] thermo_clean, load_word;
    logic              load_bubble;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FF; gi++) begin : g_thermo
            assign thermo_clean[gi] = (load_bin > BW'(gi));
        end
    endgenerate

`ifdef TDC_BUBBLE_INJECT_EN
    localparam int IW = $clog2(NUM_FF);
    logic [15:0]   lfsr_reg;
    logic [IW-1:0] bub_lo, bub_hi;

    assign bub_lo      = IW'(load_bin - BW'(2));
    assign bub_hi      = IW'(load_bin + BW'(1));
    assign load_bubble = lfsr_reg[0] && (load_bin >= BW'(2)) && (load_bin <= BW'(NUM_FF - 2));

    // moving one 1 from below the edge to just above it keeps the ones count equal to b
    always_comb begin
        load_word = thermo_clean;
        if (load_bubble) begin
            load_word[bub_lo] = 1'b0;
            load_word[bub_hi] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else if (load_en) begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
    end
`else
    assign load_bubble = 1'b0;
    assign load_word   = thermo_clean;
`endif

    // ---------------- registered state and outputs ----------------
    logic [NUM_FF-1:0]    thermo_reg;
    logic [BITS_DECO-1:0] echo_reg;
    logic                 valid_reg, sat_reg, bubble_reg, done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sweep_bin_reg <= '0;
            step_reg      <= '0;
            thermo_reg    <= '0;
            echo_reg      <= '0;
            valid_reg     <= 1'b0;
            sat_reg       <= 1'b0;
            bubble_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sweep_bin_reg <= sweep_bin_next;
            step_reg      <= step_next;
            done_reg      <= done_next;
            if (load_en) begin
                thermo_reg <= load_word;
                echo_reg   <= load_bin[BITS_DECO-1:0];
                valid_reg  <= 1'b1;
                sat_reg    <= load_sat;
                bubble_reg <= load_bubble;
            end else if (clear_out) begin
                thermo_reg <= '0;
                echo_reg   <= '0;
                valid_reg  <= 1'b0;
                sat_reg    <= 1'b0;
                bubble_reg <= 1'b0;
            end
        end
    end

    assign o_thermo       = thermo_reg;
    assign o_thermo_valid = valid_reg;
    assign o_bin_echo     = echo_reg;
    assign o_sat          = sat_reg;
    assign o_bubble       = bubble_reg;
    assign o_busy         = (state_reg != IDLE);
    assign o_sweep_done   = done_reg;
endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Self-checking bench for tdc_thermo_encoder: directed cases plus random requests and sweeps,
// scored against a word-level expectation queue built from the bin/thermometer rules.
`timescale 1ns/1ps
module tb_tdc_thermo_encoder;
    localparam int NUM_FF     = 240;
    localparam int BITS_DECO  = 8;
    localparam int HOLD_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct { int bin; bit sat; } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_sweep_start = 1'b0;
    logic [BITS_DECO-1:0] i_sweep_step = '0;
    logic [HOLD_W-1:0]    i_hold_cycles = '0;
    logic [NUM_FF-1:0]    o_thermo;
    logic                 o_thermo_valid;
    logic [BITS_DECO-1:0] o_bin_echo;
    logic                 o_sat, o_bubble, o_busy, o_sweep_done;

    tdc_thermo_encoder_if #(.BITS_DECO(BITS_DECO)) req_if ();

    tdc_thermo_encoder #(
        .NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO), .HOLD_W(HOLD_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req_if),
        .i_sweep_start(i_sweep_start), .i_sweep_step(i_sweep_step), .i_hold_cycles(i_hold_cycles),
        .o_thermo(o_thermo), .o_thermo_valid(o_thermo_valid), .o_bin_echo(o_bin_echo),
        .o_sat(o_sat), .o_bubble(o_bubble), .o_busy(o_busy), .o_sweep_done(o_sweep_done)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   cyc = 0, run_len = 0, last_run = 0, words_seen = 0;
    int   done_cnt = 0, sweeps_exp = 0, bubble_cnt = 0;
    int   cur_bin = 0, last_echo = 0;
    bit   cur_sat = 1'b0, prev_done = 1'b0;
    int   edge_bins [10] = '{0, 1, 2, 3, 237, 238, 239, 240, 241, 255};

    task automatic check(input string tag, input logic [NUM_FF-1:0] obs, input logic [NUM_FF-1:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NUM_FF-1:0] thermo_of(input int b, input bit bub);
        logic [NUM_FF-1:0] w;
        for (int i = 0; i < NUM_FF; i++) w[i] = (i < b);
        if (bub) begin
            w[b-2] = 1'b0;
            w[b+1] = 1'b1;
        end
        return w;
    endfunction

    // word-level monitor: each word must match the next expectation and last hold+1 cycles
    always @(negedge clk) begin
        if (!mon_en) begin
            cyc     = 0;
            run_len = 0;
        end else begin
            if (o_sweep_done) begin
                done_cnt++;
                check("done_valid_low", o_thermo_valid, 0);
                check("done_after_last", last_echo, NUM_FF);
                check("done_pulse_width", prev_done, 0);
            end
            if (o_thermo_valid) begin
                bit exp_bub;
                check("busy_with_valid", o_busy, 1);
                if (cyc == 0) begin
                    words_seen++;
                    if (exp_q.size() == 0) begin
                        check("extra_word", exp_q.size(), 1);
                        cur_bin = -1;
                        cur_sat = 1'b0;
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        cur_bin = e.bin;
                        cur_sat = e.sat;
                    end
                    check("echo", o_bin_echo, cur_bin);
                    check("sat", o_sat, cur_sat);
                    $display("word bin=%0d sat=%0b bubble=%0b hold=%0d", o_bin_echo, o_sat, o_bubble, i_hold_cycles);
                end
                exp_bub = 1'b0;
`ifdef TDC_BUBBLE_INJECT_EN
                if (o_bubble) begin
                    bubble_cnt++;
                    exp_bub = (cur_bin >= 2 && cur_bin <= NUM_FF - 2);
                    check("bubble_range", exp_bub, 1);
                end
                check("ones_count", $countones(o_thermo), o_bin_echo);
`else
                check("no_bubble", o_bubble, 0);
`endif
                check("thermo", o_thermo, thermo_of(cur_bin, exp_bub));
                last_echo = o_bin_echo;
                run_len++;
                cyc = (cyc >= int'(i_hold_cycles)) ? 0 : cyc + 1;
            end else begin
                check("hold_len", cyc, 0);
                if (run_len > 0) last_run = run_len;
                run_len = 0;
                cyc     = 0;
                check("idle_thermo", o_thermo, 0);
                check("idle_echo", o_bin_echo, 0);
                check("idle_sat", o_sat, 0);
                check("idle_bubble", o_bubble, 0);
            end
        end
        prev_done = o_sweep_done;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input int b);
        bit acc = 1'b0;
        req_if.i_bin_valid = 1'b1;
        req_if.i_bin       = BITS_DECO'(b);
        for (int t = 0; t < 2000; t++) begin
            acc = req_if.o_bin_ready;
            if (acc) begin
                exp_t e;
                e.bin = (b > NUM_FF) ? NUM_FF : b;
                e.sat = (b > NUM_FF);
                exp_q.push_back(e);
            end
            tick();
            if (acc) break;
        end
        req_if.i_bin_valid = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic queue_sweep(input int step);
        int   s = (step == 0) ? 1 : step;
        exp_t e;
        e.sat = 1'b0;
        for (int b = 0; b < NUM_FF; b += s) begin
            e.bin = b;
            exp_q.push_back(e);
        end
        e.bin = NUM_FF;
        exp_q.push_back(e);
        sweeps_exp++;
    endtask

    task automatic start_sweep(input int step);
        i_sweep_start = 1'b1;
        i_sweep_step  = BITS_DECO'(step);
        queue_sweep(step);
        tick();
        i_sweep_start = 1'b0;
    endtask

    task automatic wait_idle();
        int idle_n = 0;
        for (int t = 0; t < 5000 && idle_n < 2; t++) begin
            tick();
            idle_n = o_busy ? 0 : idle_n + 1;
        end
        check("idle_reached", (idle_n >= 2), 1);
        tick();
        check("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        req_if.i_bin_valid = 1'b0;
        req_if.i_bin       = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_thermo", o_thermo, 0);
        check("rst_valid", o_thermo_valid, 0);
        check("rst_echo", o_bin_echo, 0);
        check("rst_sat", o_sat, 0);
        check("rst_bubble", o_bubble, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_sweep_done, 0);
        check("rst_ready", req_if.o_bin_ready, 1);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // latency: valid one edge after accept, for exactly hold+1 = 1 cycle
        i_hold_cycles = '0;
        push_req(37);
        check("lat_accept_edge", o_thermo_valid, 0);
        tick();
        check("lat_next_edge", o_thermo_valid, 1);
        check("lat_echo", o_bin_echo, 37);
        tick();
        check("lat_one_cycle", o_thermo_valid, 0);
        wait_idle();

        // boundary bins: zero, full, saturated
        w0 = words_seen;
        push_req(0);
        push_req(240);
        push_req(250);
        wait_idle();
        check("boundary_words", words_seen - w0, 3);

        // back-to-back with hold=3: FIFO fills, words are gap-free
        i_hold_cycles = 8'd3;
        w0 = words_seen;
        for (int k = 0; k < 5; k++) push_req(10 + 20 * k);
        check("ready_full", req_if.o_bin_ready, 0);
        wait_idle();
        check("gapfree_run", last_run, 20);
        check("b2b_words", words_seen - w0, 5);

        // sweep step 0 -> every bin 0..240
        i_hold_cycles = '0;
        w0 = words_seen;
        d0 = done_cnt;
        start_sweep(0);
        wait_idle();
        check("sweep0_words", words_seen - w0, 241);
        check("sweep0_done", done_cnt - d0, 1);

        // sweep step 7 with hold 1 -> last word clamped to 240
        i_hold_cycles = 8'd1;
        w0 = words_seen;
        start_sweep(7);
        wait_idle();
        check("sweep7_words", words_seen - w0, 36);

        // sweep start beats a simultaneous push; restart during sweep is ignored
        i_hold_cycles = '0;
        d0 = done_cnt;
        req_if.i_bin_valid = 1'b1;
        req_if.i_bin       = 8'd99;
        i_sweep_start      = 1'b1;
        i_sweep_step       = 8'd60;
        queue_sweep(60);
        exp_q.push_back('{bin: 99, sat: 1'b0});
        tick();
        req_if.i_bin_valid = 1'b0;
        i_sweep_start      = 1'b0;
        repeat (2) tick();
        i_sweep_start = 1'b1;
        i_sweep_step  = 8'd1;
        tick();
        i_sweep_start = 1'b0;
        i_sweep_step  = 8'd60;
        wait_idle();
        check("sweep_wins_done", done_cnt - d0, 1);

        // step 1 sweep: ones count must track the bin; bubbles appear only when enabled
        bubble_cnt = 0;
        start_sweep(1);
        wait_idle();
`ifdef TDC_BUBBLE_INJECT_EN
        check("bubble_seen", (bubble_cnt > 0), 1);
`else
        check("bubble_seen", bubble_cnt, 0);
`endif

        // random requests and sweeps
        for (int r = 0; r < 30; r++) begin
            i_hold_cycles = HOLD_W'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                i_hold_cycles = HOLD_W'($urandom_range(0, 1));
                start_sweep(int'($urandom_range(0, 255)));
            end
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                int b;
                b = ($urandom_range(0, 2) == 0) ? edge_bins[$urandom_range(0, 9)] : int'($urandom_range(0, 255));
                push_req(b);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle();
        end

        // asynchronous reset in the middle of a held word
        i_hold_cycles = 8'd10;
        push_req(100);
        for (int t = 0; t < 20 && !o_thermo_valid; t++) tick();
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_thermo", o_thermo, 0);
        check("arst_valid", o_thermo_valid, 0);
        check("arst_echo", o_bin_echo, 0);
        check("arst_busy", o_busy, 0);
        check("arst_ready", req_if.o_bin_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        i_hold_cycles = '0;
        tick();
        mon_en = 1'b1;
        push_req(5);
        wait_idle();

        check("sweep_done_total", done_cnt, sweeps_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
